// File: rtl/multi_add_top.sv
// N-channel joined add/subtract with FWFT input FIFOs and a buffered output FIFO.
// Define MULTI_ADD_SAT_EN to saturate the scaled sum instead of wrapping it.
module multi_add_top #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int IN_DEPTH   = 32,
  parameter int OUT_DEPTH  = 32,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              in_wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   in_din,
  output logic [NUM_CH-1:0]              in_full,
  output logic [NUM_CH-1:0]              in_ovf,
  input  logic [NUM_CH-1:0]              sub_mask,
  input  logic                           out_rd_en,
  output logic                           out_empty,
  output logic [DATA_WIDTH-1:0]          out_dout,
  output logic [$clog2(OUT_DEPTH):0]     out_count
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CHW = $clog2(NUM_CH);
  localparam int SW  = DATA_WIDTH + CHW;

  logic [NUM_CH*DATA_WIDTH-1:0] heads;
  logic [NUM_CH-1:0]            nempty;
  logic                         pop;

  genvar k;
  for (k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [IN_DEPTH];
    logic [IAW:0]          wp_q;
    logic [IAW:0]          wp_d;
    logic [IAW:0]          rp_q;
    logic [IAW:0]          rp_d;
    logic [IAW:0]          cnt;
    logic                  wr;
    logic                  ovf_q;

    assign cnt        = wp_q - rp_q;
    assign in_full[k] = (cnt == (IAW+1)'(IN_DEPTH));
    assign nempty[k]  = (cnt != '0);
    assign wr         = in_wr_en[k] && !in_full[k];
    assign wp_d       = wr  ? wp_q + 1'b1 : wp_q;
    assign rp_d       = pop ? rp_q + 1'b1 : rp_q;
    assign in_ovf[k]  = ovf_q;

    assign heads[k*DATA_WIDTH +: DATA_WIDTH] =
      mem_q[rp_q[IAW-1:0]];

    always_ff @(posedge clock) begin
      if (wr) begin
        mem_q[wp_q[IAW-1:0]] <=
          in_din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wp_q  <= '0;
        rp_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        wp_q <= wp_d;
        rp_q <= rp_d;
        if (in_wr_en[k] && in_full[k]) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [OAW:0]          occ;

  // Credit counts the word already in s1 so its write can never be refused.
  assign occ = out_count + (OAW+1)'(s1_valid_q);
  assign pop = (&nempty) && (occ < (OAW+1)'(OUT_DEPTH));

  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  shifted;
  logic [DATA_WIDTH-1:0] reduced;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sub_mask[i]) begin
        sum = sum - SW'($signed(heads[i*DATA_WIDTH +: DATA_WIDTH]));
      end else begin
        sum = sum + SW'($signed(heads[i*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  assign shifted = sum >>> OUT_SHIFT;

`ifdef MULTI_ADD_SAT_EN
  logic [CHW:0] hi;

  assign hi = shifted[SW-1:DATA_WIDTH-1];

  always_comb begin
    reduced = shifted[DATA_WIDTH-1:0];
    if (!((&hi) || !(|hi))) begin
      if (shifted[SW-1]) begin
        reduced = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        reduced = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  logic [CHW-1:0] unused_hi;

  assign unused_hi = shifted[SW-1:DATA_WIDTH];
  assign reduced   = shifted[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= pop;
      if (pop) begin
        s1_data_q <= reduced;
      end
    end
  end

  logic [DATA_WIDTH-1:0] omem_q [OUT_DEPTH];
  logic [OAW:0]          owp_q;
  logic [OAW:0]          owp_d;
  logic [OAW:0]          orp_q;
  logic [OAW:0]          orp_d;
  logic                  ord;

  assign out_count = owp_q - orp_q;
  assign out_empty = (out_count == '0);
  assign ord       = out_rd_en && !out_empty;
  assign owp_d     = s1_valid_q ? owp_q + 1'b1 : owp_q;
  assign orp_d     = ord ? orp_q + 1'b1 : orp_q;
  assign out_dout  = out_empty ? '0 : omem_q[orp_q[OAW-1:0]];

  always_ff @(posedge clock) begin
    if (s1_valid_q) begin
      omem_q[owp_q[OAW-1:0]] <= s1_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owp_q <= '0;
      orp_q <= '0;
    end else begin
      owp_q <= owp_d;
      orp_q <= orp_d;
    end
  end

endmodule

// File: tb/tb_multi_add_top.sv
// Directed bench: 32-bit 4-channel instance plus a 16-bit instance with OUT_SHIFT=1.
module tb_multi_add_top;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  logic [3:0]   wr_en;
  logic [127:0] din;
  logic [3:0]   full;
  logic [3:0]   ovf;
  logic [3:0]   sub;
  logic         rd;
  logic         empty;
  logic [31:0]  dout;
  logic [5:0]   cnt;

  logic [3:0]   wr_en16;
  logic [63:0]  din16;
  logic [3:0]   full16;
  logic [3:0]   ovf16;
  logic [3:0]   sub16;
  logic         rd16;
  logic         empty16;
  logic [15:0]  dout16;
  logic [5:0]   cnt16;

  int checks = 0;
  int failures = 0;

  logic [31:0] got [0:127];
  int          gotn;

  multi_add_top dut (
    .clock    (clock),
    .reset    (reset),
    .in_wr_en (wr_en),
    .in_din   (din),
    .in_full  (full),
    .in_ovf   (ovf),
    .sub_mask (sub),
    .out_rd_en(rd),
    .out_empty(empty),
    .out_dout (dout),
    .out_count(cnt)
  );

  multi_add_top #(
    .DATA_WIDTH(16),
    .OUT_SHIFT (1)
  ) dut16 (
    .clock    (clock),
    .reset    (reset),
    .in_wr_en (wr_en16),
    .in_din   (din16),
    .in_full  (full16),
    .in_ovf   (ovf16),
    .sub_mask (sub16),
    .out_rd_en(rd16),
    .out_empty(empty16),
    .out_dout (dout16),
    .out_count(cnt16)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr4(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] d);
    wr_en = 4'hF;
    din   = {d, c, b, a};
    tick();
    wr_en = 4'h0;
  endtask

  task automatic pop1();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic drain(input int n);
    gotn = 0;
    rd   = 1'b1;
    for (int c = 0; c < 400 && gotn < n; c++) begin
      if (!empty) begin
        got[gotn] = dout;
        gotn++;
      end
      tick();
    end
    rd = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (full !== 4'h0) begin
      failures++;
      $display("FAIL rst_full got=%h exp=0", full);
    end
    checks++;
    if (ovf !== 4'h0) begin
      failures++;
      $display("FAIL rst_ovf got=%h exp=0", ovf);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL rst_empty got=%b exp=1", empty);
    end
    checks++;
    if (dout !== 32'd0) begin
      failures++;
      $display("FAIL rst_dout got=%h exp=0", dout);
    end
    checks++;
    if (cnt !== 6'd0) begin
      failures++;
      $display("FAIL rst_count got=%0d exp=0", cnt);
    end
  endtask

  task automatic test_basic();
    sub = 4'h0;
    wr4(1, 2, 3, 4);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty_t got=%b exp=1", empty);
    end
    tick();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty_t1 got=%b exp=1", empty);
    end
    tick();
    checks++;
    if (empty !== 1'b0 || dout !== 32'd10 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL basic_out got=%0d/%b/%0d exp=10/0/1",
               dout, empty, cnt);
    end
    pop1();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_pop got=%b exp=1", empty);
    end
  endtask

  task automatic test_sub();
    sub = 4'b0010;
    wr4(100, 30, 5, 5);
    tick();
    tick();
    checks++;
    if (dout !== 32'd80) begin
      failures++;
      $display("FAIL sub_80 got=%0d exp=80", $signed(dout));
    end
    pop1();
    sub = 4'b1111;
    wr4(1, 2, 3, 4);
    tick();
    tick();
    checks++;
    if (dout !== 32'hFFFF_FFF6) begin
      failures++;
      $display("FAIL sub_neg got=%0d exp=-10", $signed(dout));
    end
    pop1();
    sub = 4'h0;
  endtask

  task automatic test_sat16();
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
`ifdef MULTI_ADD_SAT_EN
    exp_hi = 16'h7FFF;
    exp_lo = 16'h8000;
`else
    exp_hi = 16'hFFFE;
    exp_lo = 16'h0000;
`endif
    sub16   = 4'h0;
    wr_en16 = 4'hF;
    din16   = {4{16'h7FFF}};
    tick();
    wr_en16 = 4'h0;
    tick();
    tick();
    checks++;
    if (dout16 !== exp_hi) begin
      failures++;
      $display("FAIL w16_max got=%h exp=%h", dout16, exp_hi);
    end
    rd16 = 1'b1;
    tick();
    rd16 = 1'b0;
    wr_en16 = 4'hF;
    din16   = {16'h0, 16'h0, 16'h0, 16'hFFFD};
    tick();
    wr_en16 = 4'h0;
    tick();
    tick();
    checks++;
    if (dout16 !== 16'hFFFE) begin
      failures++;
      $display("FAIL w16_shift got=%h exp=fffe", dout16);
    end
    rd16 = 1'b1;
    tick();
    rd16 = 1'b0;
    wr_en16 = 4'hF;
    din16   = {4{16'h8000}};
    tick();
    wr_en16 = 4'h0;
    tick();
    tick();
    checks++;
    if (dout16 !== exp_lo || empty16 !== 1'b0) begin
      failures++;
      $display("FAIL w16_min got=%h/%b exp=%h/0",
               dout16, empty16, exp_lo);
    end
    rd16 = 1'b1;
    tick();
    rd16 = 1'b0;
  endtask

  task automatic test_back_to_back();
    rd = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wr_en = 4'hF;
      din   = {4{32'(n + 1)}};
      tick();
    end
    wr_en = 4'h0;
    tick();
    checks++;
    if (cnt !== 6'd3) begin
      failures++;
      $display("FAIL b2b_cnt3 got=%0d exp=3", cnt);
    end
    tick();
    checks++;
    if (cnt !== 6'd4) begin
      failures++;
      $display("FAIL b2b_cnt4 got=%0d exp=4", cnt);
    end
    drain(4);
    checks++;
    if (gotn != 4) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d exp=4", gotn);
    end
    for (int i = 0; i < gotn; i++) begin
      checks++;
      if (got[i] !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL b2b_data[%0d] got=%0d exp=%0d",
                 i, got[i], 4 * i + 4);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin
      wr_en      = 4'b0001;
      din        = '0;
      din[31:0]  = 32'(i + 1);
      tick();
    end
    wr_en = 4'h0;
    checks++;
    if (full !== 4'b0001 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_fill got=%h/%h exp=1/0", full, ovf);
    end
    wr_en     = 4'b0001;
    din[31:0] = 32'd999;
    tick();
    wr_en = 4'h0;
    tick();
    checks++;
    if (ovf !== 4'b0001 || full !== 4'b0001 || empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_33rd got=%h/%h/%b exp=1/1/1",
               ovf, full, empty);
    end
    for (int j = 0; j < 32; j++) begin
      wr_en = 4'b1110;
      din   = {32'(j), 32'(j), 32'(j), 32'd0};
      tick();
    end
    wr_en = 4'h0;
    tick();
    tick();
    tick();
    checks++;
    if (cnt !== 6'd32 || full !== 4'h0) begin
      failures++;
      $display("FAIL ovf_cnt got=%0d/%h exp=32/0", cnt, full);
    end
    drain(32);
    checks++;
    if (gotn != 32) begin
      failures++;
      $display("FAIL ovf_timeout got=%0d exp=32", gotn);
    end
    for (int i = 0; i < gotn; i++) begin
      checks++;
      if (got[i] !== 32'(4 * i + 1)) begin
        failures++;
        $display("FAIL ovf_data[%0d] got=%0d exp=%0d",
                 i, got[i], 4 * i + 1);
      end
    end
    checks++;
    if (ovf !== 4'b0001 || empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%h/%b exp=1/1", ovf, empty);
    end
  endtask

  task automatic test_backpressure();
    rd = 1'b0;
    for (int n = 0; n < 64; n++) begin
      wr_en = 4'hF;
      din   = {4{32'(n)}};
      tick();
    end
    wr_en = 4'h0;
    tick();
    tick();
    tick();
    checks++;
    if (cnt !== 6'd32 || full !== 4'hF || ovf !== 4'b0001) begin
      failures++;
      $display("FAIL bp_stall got=%0d/%h/%h exp=32/f/1",
               cnt, full, ovf);
    end
    drain(64);
    checks++;
    if (gotn != 64) begin
      failures++;
      $display("FAIL bp_timeout got=%0d exp=64", gotn);
    end
    for (int i = 0; i < gotn; i++) begin
      checks++;
      if (got[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL bp_data[%0d] got=%0d exp=%0d",
                 i, got[i], 4 * i);
      end
    end
    tick();
    tick();
    checks++;
    if (empty !== 1'b1 || cnt !== 6'd0) begin
      failures++;
      $display("FAIL bp_extra got=%b/%0d exp=1/0", empty, cnt);
    end
  endtask

  task automatic test_reset_mid();
    wr4(5, 5, 5, 5);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || cnt !== 6'd0 || dout !== 32'd0 ||
        full !== 4'h0 || ovf !== 4'h0) begin
      failures++;
      $display("FAIL mid_rst got=%b/%0d/%0d/%h/%h exp=1/0/0/0/0",
               empty, cnt, dout, full, ovf);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1 || cnt !== 6'd0) begin
      failures++;
      $display("FAIL mid_flush got=%b/%0d exp=1/0", empty, cnt);
    end
    wr4(1, 1, 1, 1);
    tick();
    tick();
    checks++;
    if (dout !== 32'd4 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL mid_post got=%0d/%0d exp=4/1", dout, cnt);
    end
    pop1();
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 4'h0;
    din     = '0;
    sub     = 4'h0;
    rd      = 1'b0;
    wr_en16 = 4'h0;
    din16   = '0;
    sub16   = 4'h0;
    rd16    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_sub();
    test_sat16();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
